// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parameterised register file.
// Optional same-cycle write bypass is enabled by defining REG_FILE_BYPASS_EN.
package reg_file_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } rf_state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_NUM_RD = 2;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: array mux plus optional write bypass.
// Bypass path is compiled in only when REG_FILE_BYPASS_EN is defined.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [(2**ADDR_W)*DATA_W-1:0] i_mem,
   input  logic [ADDR_W-1:0]             i_addr,
   input  logic                          i_byp_vld,
   input  logic [ADDR_W-1:0]             i_byp_addr,
   input  logic [DATA_W-1:0]             i_byp_data,
   output logic [DATA_W-1:0]             o_data
);

   logic [DATA_W-1:0] w_arr;

   assign w_arr = i_mem[i_addr*DATA_W +: DATA_W];

`ifdef REG_FILE_BYPASS_EN
   assign o_data = (i_byp_vld && (i_byp_addr == i_addr)) ?
                   i_byp_data : w_arr;
`else
   logic w_unused;
   assign w_unused = &{1'b0, i_byp_vld, i_byp_addr, i_byp_data};
   assign o_data   = w_arr;
`endif

endmodule

// File: rtl/reg_file_param.sv
// Multi-read-port register file with a sequential whole-array clear.
// Define REG_FILE_BYPASS_EN to forward accepted write data to reads.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        write_addr,
   input  logic [DATA_W-1:0]        write_data,
   input  logic [NUM_RD*ADDR_W-1:0] read_addr,
   output logic [NUM_RD*DATA_W-1:0] read_data,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     wr_drop
);

   localparam int DEPTH = 2**ADDR_W;

   rf_state_t         r_state;
   rf_state_t         w_state_nxt;
   logic [ADDR_W-1:0] r_clr_ptr;
   logic [ADDR_W-1:0] w_clr_ptr_nxt;
   logic              r_wr_drop;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [DEPTH*DATA_W-1:0] w_mem_flat;
   logic                    w_wr_ok;

   assign busy    = (r_state == CLEAR);
   assign wr_drop = r_wr_drop;
   assign w_wr_ok = wr_en && !busy;

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      unique case (r_state)
         IDLE: begin
            if (clr_req) begin
               w_state_nxt   = CLEAR;
               w_clr_ptr_nxt = '0;
            end
         end
         CLEAR: begin
            w_clr_ptr_nxt = r_clr_ptr + 1'b1;
            if (&r_clr_ptr)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= CLEAR;
         r_clr_ptr <= '0;
         r_wr_drop <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
         r_wr_drop <= wr_en && busy;
      end
   end

   // Reset cycle writes nothing; the clear it starts rewrites every entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy)
            r_mem[r_clr_ptr] <= '0;
         else if (wr_en)
            r_mem[write_addr] <= write_data;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign w_mem_flat[g*DATA_W +: DATA_W] = r_mem[g];
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      reg_file_rd_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rd (
         .i_mem      (w_mem_flat),
         .i_addr     (read_addr[p*ADDR_W +: ADDR_W]),
         .i_byp_vld  (w_wr_ok),
         .i_byp_addr (write_addr),
         .i_byp_data (write_data),
         .o_data     (read_data[p*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param against an array-level model.
// Honours REG_FILE_BYPASS_EN to pick the expected read behaviour.
module tb_reg_file_param;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NR = 2;
   localparam int DEPTH = 16;
`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] write_addr;
   logic [DW-1:0] write_data;
   logic [NR*AW-1:0] read_addr;
   logic [NR*DW-1:0] read_data;
   logic          clr_req;
   logic          busy;
   logic          wr_drop;

   reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .write_addr (write_addr),
      .write_data (write_data),
      .read_addr  (read_addr),
      .read_data  (read_data),
      .clr_req    (clr_req),
      .busy       (busy),
      .wr_drop    (wr_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NR*DW-1:0] rd;
      bit               busy;
      bit               drop;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Model: array contents, clear cycles remaining, pending drop flag.
   logic [DW-1:0] m_mem [DEPTH];
   int            m_left = 0;
   bit            m_drop = 0;

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (read_data !== e.rd) begin
            errors++;
            $display("FAIL read_data t=%0t got=%h exp=%h", $time, read_data, e.rd);
         end
         checks++;
         if (busy !== e.busy) begin
            errors++;
            $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e.busy);
         end
         checks++;
         if (wr_drop !== e.drop) begin
            errors++;
            $display("FAIL wr_drop t=%0t got=%b exp=%b", $time, wr_drop, e.drop);
         end
      end
   end

   task automatic drive(input bit rst, input bit we, input int wa,
                        input logic [DW-1:0] wd, input bit clr,
                        input int ra0, input int ra1);
      exp_t e;
      int   ra;
      reset      = rst;
      wr_en      = we;
      write_addr = wa[AW-1:0];
      write_data = wd;
      clr_req    = clr;
      read_addr  = {ra1[AW-1:0], ra0[AW-1:0]};
      for (int i = 0; i < NR; i++) begin
         ra = (i == 0) ? ra0 : ra1;
         if (BYP && we && m_left == 0 && ra == wa)
            e.rd[i*DW +: DW] = wd;
         else
            e.rd[i*DW +: DW] = m_mem[ra];
      end
      e.busy = (m_left > 0);
      e.drop = m_drop;
      q.push_back(e);
      if (rst) begin
         m_left = DEPTH;
         m_drop = 0;
      end else begin
         m_drop = we && (m_left > 0);
         if (m_left > 0) begin
            m_mem[DEPTH - m_left] = '0;
            m_left--;
         end else begin
            if (we) m_mem[wa] = wd;
            if (clr) m_left = DEPTH;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int ra0, input int ra1);
      drive(0, 0, 0, '0, 0, ra0, ra1);
   endtask

   task automatic check_busy_len(input string name, input int n);
      checks++;
      if (n != DEPTH) begin
         errors++;
         $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, DEPTH);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      reset = 1'b1; wr_en = 1'b1; clr_req = 1'b0;
      write_addr = '0; write_data = 32'hdead; read_addr = '0;
      @(posedge clk);
      #1;
      reset = 1'b0; wr_en = 1'b0;
      checks++;
      if (wr_drop !== 1'b0) begin
         errors++;
         $display("FAIL reset_wr_drop got=%b exp=0", wr_drop);
      end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(posedge clk);
         #1;
      end
      check_busy_len("reset_clear", n);

      for (int i = 0; i < DEPTH; i += 2) idle(i, i + 1);

      drive(0, 1, 1, 32'd52, 0, 1, 0);
      idle(1, 0);
      drive(0, 1, 2, 32'd62, 0, 2, 1);
      idle(2, 2);
      idle(1, 2);

      drive(0, 0, 0, '0, 1, 3, 1);
      idle(3, 1);
      drive(0, 1, 3, 32'd99, 0, 3, 2);
      n = 0;
      while (m_left > 0 && n < 40) begin
         idle(3, n % DEPTH);
         n++;
      end
      idle(3, 1);

      drive(0, 0, 0, '0, 1, 1, 2);
      for (int i = 0; i < 7; i++) idle(i, 15 - i);
      drive(1, 0, 0, '0, 0, 0, 1);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         drive(0, 1, n % DEPTH, 32'(n), (n == 3), n % DEPTH, 5);
         n++;
      end
      check_busy_len("mid_clear_reset", n);

      drive(0, 1, 5, 32'd7, 1, 5, 4);
      for (int i = 0; i < DEPTH; i++) idle(5, 4);
      idle(5, 5);

      for (int k = 0; k < 300; k++) begin
         drive(($urandom_range(99) == 0), $urandom_range(1),
               $urandom_range(DEPTH - 1), $urandom,
               ($urandom_range(29) == 0),
               $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1));
      end
      while (m_left > 0) idle(0, 1);
      for (int i = 0; i < DEPTH; i += 2) idle(i, i + 1);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
